// File: rtl/rdmx_rcv_be.sv
// Receive-side back end of the RDMX link: turns (length, address, data) AXI-Stream
// triples into AXI4 INCR write bursts and tracks outstanding B responses.
module rdmx_rcv_be #(
  parameter int DATA_WBITS      = 512,
  parameter int ADDR_WBITS      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             AXIS_PLEN_TDATA,
  input  logic                    AXIS_PLEN_TVALID,
  output logic                    AXIS_PLEN_TREADY,
  input  logic [ADDR_WBITS-1:0]   AXIS_ADDR_TDATA,
  input  logic                    AXIS_ADDR_TVALID,
  output logic                    AXIS_ADDR_TREADY,
  input  logic [DATA_WBITS-1:0]   AXIS_DATA_TDATA,
  input  logic                    AXIS_DATA_TLAST,
  input  logic                    AXIS_DATA_TVALID,
  output logic                    AXIS_DATA_TREADY,
  output logic [ADDR_WBITS-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WBITS-1:0]   M_AXI_WDATA,
  output logic [DATA_WBITS/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [31:0]             packets_written,
  output logic [7:0]              outstanding,
  output logic                    length_error,
  output logic                    bresp_error
);
  localparam int BPB      = DATA_WBITS / 8;
  localparam int LOG2_BPB = $clog2(BPB);
  localparam int MAX_PLEN = 256 * BPB;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_PAD, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              beat_q, beat_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [LOG2_BPB-1:0]     rem_q, rem_d;
  logic [ADDR_WBITS-1:0]   addr_q, addr_d;
  logic [31:0]             pkts_q, pkts_d;
  logic [7:0]              outst_q, outst_d;
  logic                    len_err_q, len_err_d;
  logic                    bresp_err_q, bresp_err_d;
  logic                    bready_q, bready_d;

  logic [16:0]             plen_m1;
  logic                    plen_bad;
  logic                    room;
  logic                    wlast_hs;
  logic                    b_hs;

  // Low rem byte lanes enabled; rem == 0 means the final beat is full.
  function automatic logic [BPB-1:0] tail_strb(input logic [LOG2_BPB-1:0] r);
    logic [BPB-1:0] m;
    m = '1;
    if (r != '0) m = m >> (BPB - int'(r));
    return m;
  endfunction

  assign plen_m1  = {1'b0, AXIS_PLEN_TDATA} - 17'd1;
  assign plen_bad = (AXIS_PLEN_TDATA == 16'd0) || (32'(AXIS_PLEN_TDATA) > 32'(MAX_PLEN));
  assign room     = int'(outst_q) < MAX_OUTSTANDING;

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    awlen_d          = awlen_q;
    rem_d            = rem_q;
    addr_d           = addr_q;
    pkts_d           = pkts_q;
    len_err_d        = len_err_q;
    bresp_err_d      = bresp_err_q;
    bready_d         = 1'b1;
    wlast_hs         = 1'b0;
    AXIS_PLEN_TREADY = 1'b0;
    AXIS_ADDR_TREADY = 1'b0;
    AXIS_DATA_TREADY = 1'b0;
    M_AXI_AWVALID    = 1'b0;
    M_AXI_WVALID     = 1'b0;
    M_AXI_WDATA      = '0;
    M_AXI_WSTRB      = '0;
    M_AXI_WLAST      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (AXIS_PLEN_TVALID && AXIS_ADDR_TVALID && room && !reset) begin
          AXIS_PLEN_TREADY = 1'b1;
          AXIS_ADDR_TREADY = 1'b1;
          addr_d  = AXIS_ADDR_TDATA;
          awlen_d = 8'(plen_m1 >> LOG2_BPB);
          rem_d   = AXIS_PLEN_TDATA[LOG2_BPB-1:0];
          if (plen_bad) begin
            len_err_d = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            state_d   = S_AW;
          end
        end
      end
      S_AW: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) begin
          beat_d  = 8'd0;
          state_d = S_W;
        end
      end
      S_W: begin
        M_AXI_WVALID     = AXIS_DATA_TVALID;
        AXIS_DATA_TREADY = M_AXI_WREADY;
        M_AXI_WDATA      = AXIS_DATA_TDATA;
        M_AXI_WLAST      = (beat_q == awlen_q);
        M_AXI_WSTRB      = M_AXI_WLAST ? tail_strb(rem_q) : '1;
        if (AXIS_DATA_TVALID && M_AXI_WREADY) begin
          beat_d = beat_q + 8'd1;
          if (M_AXI_WLAST) begin
            wlast_hs = 1'b1;
            pkts_d   = pkts_q + 32'd1;
            if (!AXIS_DATA_TLAST) begin
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end else begin
              state_d   = S_IDLE;
            end
          end else if (AXIS_DATA_TLAST) begin
            // Short packet: finish the announced burst with null beats.
            len_err_d = 1'b1;
            state_d   = S_PAD;
          end
        end
      end
      S_PAD: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = (beat_q == awlen_q);
        if (M_AXI_WREADY) begin
          beat_d = beat_q + 8'd1;
          if (M_AXI_WLAST) begin
            wlast_hs = 1'b1;
            pkts_d   = pkts_q + 32'd1;
            state_d  = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        AXIS_DATA_TREADY = 1'b1;
        if (AXIS_DATA_TVALID && AXIS_DATA_TLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    b_hs = M_AXI_BVALID && bready_q && (outst_q != 8'd0);
    case ({wlast_hs, b_hs})
      2'b10:   outst_d = outst_q + 8'd1;
      2'b01:   outst_d = outst_q - 8'd1;
      default: outst_d = outst_q;
    endcase
    if (M_AXI_BVALID && bready_q && (M_AXI_BRESP != 2'b00)) bresp_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= 8'd0;
      pkts_q      <= 32'd0;
      outst_q     <= 8'd0;
      len_err_q   <= 1'b0;
      bresp_err_q <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pkts_q      <= pkts_d;
      outst_q     <= outst_d;
      len_err_q   <= len_err_d;
      bresp_err_q <= bresp_err_d;
      bready_q    <= bready_d;
    end
  end

  // Burst descriptor; only meaningful once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    awlen_q <= awlen_d;
    rem_q   <= rem_d;
  end

  assign M_AXI_AWADDR    = addr_q;
  assign M_AXI_AWLEN     = awlen_q;
  assign M_AXI_AWSIZE    = 3'(LOG2_BPB);
  assign M_AXI_AWBURST   = 2'b01;
  assign M_AXI_BREADY    = bready_q;
  assign packets_written = pkts_q;
  assign outstanding     = outst_q;
  assign length_error    = len_err_q;
  assign bresp_error     = bresp_err_q;
endmodule

// File: tb/tb_rdmx_rcv_be.sv
// Directed bench for rdmx_rcv_be: queued AXIS stimulus, expected AW/W beats
// scoreboarded from a packet model and compared as the DUT emits them.
module tb_rdmx_rcv_be;
  localparam int DW   = 512;
  localparam int AW   = 64;
  localparam int BPB  = DW / 8;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] plen_tdata;
  logic plen_tvalid, plen_tready;
  logic [AW-1:0] addr_tdata;
  logic addr_tvalid, addr_tready;
  logic [DW-1:0] data_tdata;
  logic data_tlast, data_tvalid, data_tready;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [DW-1:0] wdata;
  logic [BPB-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [31:0] packets_written;
  logic [7:0] outstanding;
  logic length_error, bresp_error;

  always #5 clk = ~clk;

  rdmx_rcv_be #(.DATA_WBITS(DW), .ADDR_WBITS(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .AXIS_PLEN_TDATA(plen_tdata), .AXIS_PLEN_TVALID(plen_tvalid), .AXIS_PLEN_TREADY(plen_tready),
    .AXIS_ADDR_TDATA(addr_tdata), .AXIS_ADDR_TVALID(addr_tvalid), .AXIS_ADDR_TREADY(addr_tready),
    .AXIS_DATA_TDATA(data_tdata), .AXIS_DATA_TLAST(data_tlast), .AXIS_DATA_TVALID(data_tvalid),
    .AXIS_DATA_TREADY(data_tready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .packets_written(packets_written), .outstanding(outstanding),
    .length_error(length_error), .bresp_error(bresp_error)
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} dbeat_t;
  typedef struct packed {logic [DW-1:0] data; logic [BPB-1:0] strb; logic last;} wexp_t;
  typedef struct packed {logic [AW-1:0] addr; logic [7:0] len;} awexp_t;
  typedef struct packed {logic [15:0] plen; logic [AW-1:0] addr;} req_t;

  req_t   rq[$];
  dbeat_t dq[$];
  wexp_t  wq[$];
  awexp_t awq[$];

  int tests_run = 0, tests_failed = 0;
  int aw_cnt = 0, w_cnt = 0, exp_aw_total = 0, exp_w_total = 0;
  int exp_pk = 0;
  logic exp_lerr = 1'b0;
  logic drv_en = 1'b1, wr_tog = 1'b0, wr_level = 1'b1;
  logic d_acc = 1'b0, r_acc = 1'b0;
  awexp_t ae;
  wexp_t  we;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors: sample between active edges.
  always @(negedge clk) begin
    d_acc = data_tvalid && data_tready;
    r_acc = plen_tvalid && plen_tready;
    if (!reset && awvalid && awready) begin
      aw_cnt++;
      check("aw_not_extra", 1'(aw_cnt <= exp_aw_total), 1);
      if (awq.size() > 0) begin
        ae = awq.pop_front();
        check("awaddr", awaddr, ae.addr);
        check("awlen", awlen, ae.len);
        check("awsize", awsize, 3'd6);
        check("awburst", awburst, 2'b01);
      end
    end
    if (!reset && wvalid && wready) begin
      w_cnt++;
      check("w_not_extra", 1'(w_cnt <= exp_w_total), 1);
      check("w_not_before_aw", 1'(awvalid), 0);
      if (wq.size() > 0) begin
        we = wq.pop_front();
        check("wdata", wdata, we.data);
        check("wstrb", wstrb, we.strb);
        check("wlast", wlast, we.last);
      end
    end
  end

  // Length/address source.
  initial begin
    plen_tvalid = 1'b0; addr_tvalid = 1'b0; plen_tdata = '0; addr_tdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!drv_en) begin
        plen_tvalid = 1'b0; addr_tvalid = 1'b0; rq.delete();
      end else begin
        if (plen_tvalid && r_acc) begin plen_tvalid = 1'b0; addr_tvalid = 1'b0; end
        if (!plen_tvalid && rq.size() > 0) begin
          req_t r;
          r = rq.pop_front();
          plen_tdata = r.plen; addr_tdata = r.addr;
          plen_tvalid = 1'b1; addr_tvalid = 1'b1;
        end
      end
    end
  end

  // Data source.
  initial begin
    data_tvalid = 1'b0; data_tlast = 1'b0; data_tdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!drv_en) begin
        data_tvalid = 1'b0; dq.delete();
      end else begin
        if (data_tvalid && d_acc) data_tvalid = 1'b0;
        if (!data_tvalid && dq.size() > 0) begin
          dbeat_t b;
          b = dq.pop_front();
          data_tdata = b.data; data_tlast = b.last; data_tvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (wr_tog) wready = ~wready;
      else        wready = wr_level;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Packet model: queues stimulus and the AW/W traffic it must produce.
  task automatic push_pkt(input int plen, input logic [AW-1:0] addr, input int ndata);
    int beats, rem;
    bit legal;
    logic [DW-1:0] d[$];
    dbeat_t db;
    req_t r;
    awexp_t a;
    wexp_t e;
    beats = (plen + BPB - 1) / BPB;
    rem   = plen % BPB;
    legal = (plen >= 1) && (plen <= 256 * BPB);
    for (int i = 0; i < ndata; i++) begin
      d.push_back(rand_word());
      db.data = d[i]; db.last = (i == ndata - 1);
      dq.push_back(db);
    end
    r.plen = 16'(plen); r.addr = addr;
    rq.push_back(r);
    if (legal) begin
      a.addr = addr; a.len = 8'(beats - 1);
      awq.push_back(a);
      exp_aw_total++;
      exp_pk++;
      for (int i = 0; i < beats; i++) begin
        e.last = (i == beats - 1);
        if (i < ndata) begin
          e.data = d[i];
          e.strb = '1;
          if (e.last && rem != 0) begin
            e.strb = '0;
            for (int j = 0; j < rem; j++) e.strb[j] = 1'b1;
          end
        end else begin
          e.data = '0; e.strb = '0;
        end
        wq.push_back(e);
        exp_w_total++;
      end
    end
    if (!legal || ndata != beats) exp_lerr = 1'b1;
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((rq.size() + dq.size() + wq.size() + awq.size() != 0 || data_tvalid || plen_tvalid)
           && n < budget) begin
      @(negedge clk); n++;
    end
    check("drained", rq.size() + dq.size() + wq.size() + awq.size(), 0);
    tick(); tick();
  endtask

  task automatic b_pulse(input logic [1:0] resp);
    bresp = resp; bvalid = 1'b1;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_valid_ready", {awvalid, wvalid, wlast, bready, plen_tready, addr_tready, data_tready}, 0);
    check("rst_packets", packets_written, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_flags", {length_error, bresp_error}, 0);
  endtask

  task automatic do_reset();
    drv_en = 1'b0; reset = 1'b1; wr_tog = 1'b0;
    tick(); tick();
    wq.delete(); awq.delete();
    exp_aw_total = aw_cnt; exp_w_total = w_cnt;
    exp_pk = 0; exp_lerr = 1'b0;
    check_reset_state();
    tick();
    reset = 1'b0; drv_en = 1'b1;
    tick();
  endtask

  initial begin
    int base, wbase, n;
    logic rdy_seen;
    reset = 1'b1; awready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    do_reset();

    // Two full beats.
    push_pkt(128, 64'h1000, 2);
    wait_drained(100);
    check("t1_packets", packets_written, exp_pk);
    check("t1_outstanding", outstanding, 1);
    check("t1_lerr", length_error, 0);
    b_pulse(2'b00);
    @(negedge clk);
    check("t1_outstanding_after_b", outstanding, 0);
    check("t1_bresp_err", bresp_error, 0);

    // Partial final beat.
    push_pkt(70, 64'h2040, 2);
    wait_drained(100);
    check("t2_lerr", length_error, 0);
    check("t2_packets", packets_written, exp_pk);
    b_pulse(2'b00);

    // Short packet padded, followed by a clean one.
    push_pkt(192, 64'h3000, 2);
    push_pkt(128, 64'h4000, 2);
    wait_drained(100);
    check("t3_lerr", length_error, exp_lerr);
    check("t3_packets", packets_written, exp_pk);
    check("t3_outstanding", outstanding, 2);
    b_pulse(2'b00); b_pulse(2'b00);
    @(negedge clk);
    check("t3_outstanding_after_b", outstanding, 0);

    // Long packet: excess beats drained, no extra AW.
    do_reset();
    push_pkt(64, 64'h5000, 3);
    push_pkt(64, 64'h5100, 1);
    wait_drained(100);
    check("t4_lerr", length_error, exp_lerr);
    check("t4_packets", packets_written, exp_pk);
    check("t4_aw_count", aw_cnt, exp_aw_total);
    b_pulse(2'b00); b_pulse(2'b00);

    // Illegal lengths drain silently; maximum legal length is a 256-beat burst.
    do_reset();
    push_pkt(0, 64'h6000, 1);
    push_pkt(256 * BPB + 1, 64'h6100, 2);
    push_pkt(256 * BPB, 64'h7000, 256);
    wait_drained(1500);
    check("t5_lerr", length_error, exp_lerr);
    check("t5_packets", packets_written, exp_pk);
    check("t5_aw_count", aw_cnt, exp_aw_total);
    b_pulse(2'b00);

    // Outstanding limit.
    do_reset();
    base = aw_cnt;
    push_pkt(64, 64'hA000, 1);
    push_pkt(64, 64'hA040, 1);
    push_pkt(64, 64'hA080, 1);
    repeat (30) @(negedge clk);
    check("max_outstanding", outstanding, 2);
    check("max_packets", packets_written, 2);
    check("max_aw_count", aw_cnt - base, 2);
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdy_seen = rdy_seen | addr_tready;
    end
    check("max_addr_tready_held", rdy_seen, 0);
    tick();
    b_pulse(2'b10);
    wait_drained(100);
    check("max_bresp_err", bresp_error, 1);
    check("max_packets_after", packets_written, 3);
    check("max_outstanding_after", outstanding, 2);
    b_pulse(2'b00); b_pulse(2'b00); b_pulse(2'b00);
    @(negedge clk);
    check("b_at_zero_ignored", outstanding, 0);

    // WREADY toggling, then reset mid-burst.
    do_reset();
    wbase = w_cnt;
    wr_tog = 1'b1;
    push_pkt(8 * BPB, 64'h8000, 8);
    n = 0;
    while (w_cnt - wbase < 4 && n < 100) begin @(negedge clk); n++; end
    check("tog_progress", 1'(w_cnt - wbase >= 4), 1);
    tick();
    drv_en = 1'b0; reset = 1'b1; wr_tog = 1'b0;
    tick(); tick();
    wq.delete(); awq.delete();
    exp_aw_total = aw_cnt; exp_w_total = w_cnt;
    exp_pk = 0; exp_lerr = 1'b0;
    check_reset_state();
    tick();
    reset = 1'b0; drv_en = 1'b1;
    tick();
    push_pkt(64, 64'h9000, 1);
    wait_drained(100);
    check("post_rst_packets", packets_written, 1);
    check("post_rst_lerr", length_error, 0);
    check("post_rst_outstanding", outstanding, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
